// File: rtl/joypad_pkg.sv
// Shared constants for the $4016/$4017 controller port: button bit indices,
// register addresses and the default open-bus read value.
package joypad_pkg;

    localparam int unsigned BTN_W   = 8;
    localparam int unsigned LATCH_W = 3;

    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    localparam logic [15:0] ADDR_4016 = 16'h4016;
    localparam logic [15:0] ADDR_4017 = 16'h4017;

    localparam logic [7:0] OPEN_BUS_DEFAULT = 8'h40;

endpackage

// File: rtl/joypad_shift.sv
// One standard pad: button synchroniser plus a 4021-style parallel-load,
// serial-out shift register.
module joypad_shift
    import joypad_pkg::*;
#(
    parameter logic        FILL_BIT    = 1'b1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic [BTN_W-1:0] buttons,
    input  logic             load,
    input  logic             shift,
    output logic             serial_c
);

    logic [BTN_W-1:0] sync_q [SYNC_STAGES];
    logic [BTN_W-1:0] bs;
    logic [BTN_W-1:0] sr_q;
    logic [BTN_W-1:0] sr_d;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= buttons;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign bs = sync_q[SYNC_STAGES-1];

    // Load has priority: while the strobe is high the register tracks the pad.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = bs;
        end else if (shift) begin
            sr_d = {FILL_BIT, sr_q[BTN_W-1:1]};
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    // Strobe high makes the part transparent: reads see the live A button.
    assign serial_c = load ? bs[BTN_A] : sr_q[0];

endmodule

// File: rtl/joypad_port.sv
// CPU-side $4016/$4017 responder: $4016 write latch, strobe decode and the
// read mux in front of two joypad_shift pads.
module joypad_port
    import joypad_pkg::*;
#(
    parameter logic [7:0]  OPEN_BUS    = OPEN_BUS_DEFAULT,
    parameter logic        FILL_BIT    = 1'b1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clock,
    input  logic               nreset,
    input  logic               rw,
    input  logic [7:0]         data_in,
    input  logic               addr4016w,
    input  logic               naddr4016r,
    input  logic               naddr4017r,
    input  logic [BTN_W-1:0]   buttons_p1,
    input  logic [BTN_W-1:0]   buttons_p2,
    output logic [7:0]         data_out,
    output logic               data_oe,
    output logic [LATCH_W-1:0] out_latch
);

    logic [LATCH_W-1:0] out_latch_q;
    logic [LATCH_W-1:0] out_latch_d;
    logic               strobe;
    logic               serial1;
    logic               serial2;
    logic               unused_data_in;

    assign unused_data_in = ^data_in[7:LATCH_W];

    always_comb begin
        out_latch_d = out_latch_q;
        if (addr4016w && !rw) begin
            out_latch_d = data_in[LATCH_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            out_latch_q <= '0;
        end else begin
            out_latch_q <= out_latch_d;
        end
    end

    // Load/shift use the pre-write strobe, so the clearing write does the final load.
    assign strobe    = out_latch_q[0];
    assign out_latch = out_latch_q;

    joypad_shift #(
        .FILL_BIT    (FILL_BIT),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pad1 (
        .clock    (clock),
        .nreset   (nreset),
        .buttons  (buttons_p1),
        .load     (strobe),
        .shift    (!naddr4016r),
        .serial_c (serial1)
    );

    joypad_shift #(
        .FILL_BIT    (FILL_BIT),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pad2 (
        .clock    (clock),
        .nreset   (nreset),
        .buttons  (buttons_p2),
        .load     (strobe),
        .shift    (!naddr4017r),
        .serial_c (serial2)
    );

    // $4016 wins if both read strobes are asserted together.
    always_comb begin
        data_out = {OPEN_BUS[7:1], 1'b0};
        if (!naddr4016r) begin
            data_out[0] = serial1;
        end else if (!naddr4017r) begin
            data_out[0] = serial2;
        end
    end

    assign data_oe = rw & (!naddr4016r | !naddr4017r);

endmodule

// File: tb/tb_joypad_port.sv
// Self-checking bench for joypad_port: snapshot/index pad model compared on
// every falling edge, plus directed reads with hand-computed bytes.
module tb_joypad_port;

    localparam int unsigned SYNC = 2;
    localparam logic [7:0]  OB   = 8'h40;
    localparam logic        FILL = 1'b1;

    logic       clock = 1'b0;
    logic       nreset = 1'b0;
    logic       rw = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       addr4016w = 1'b0;
    logic       naddr4016r = 1'b1;
    logic       naddr4017r = 1'b1;
    logic [7:0] buttons_p1 = 8'h00;
    logic [7:0] buttons_p2 = 8'h00;
    logic [7:0] data_out;
    logic       data_oe;
    logic [2:0] out_latch;

    int n_checks = 0;
    int n_fail   = 0;

    joypad_port #(
        .OPEN_BUS    (OB),
        .FILL_BIT    (FILL),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clock      (clock),
        .nreset     (nreset),
        .rw         (rw),
        .data_in    (data_in),
        .addr4016w  (addr4016w),
        .naddr4016r (naddr4016r),
        .naddr4017r (naddr4017r),
        .buttons_p1 (buttons_p1),
        .buttons_p2 (buttons_p2),
        .data_out   (data_out),
        .data_oe    (data_oe),
        .out_latch  (out_latch)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each pad is a snapshot byte plus a count of reads since the load.
    logic [7:0] hist1 [SYNC];
    logic [7:0] hist2 [SYNC];
    logic [7:0] snap1, snap2;
    int         cnt1, cnt2;
    logic [2:0] m_latch;

    always @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < int'(SYNC); i++) begin
                hist1[i] <= 8'h00;
                hist2[i] <= 8'h00;
            end
            snap1 <= 8'h00; snap2 <= 8'h00;
            cnt1 <= 0; cnt2 <= 0;
            m_latch <= 3'b000;
        end else begin
            if (m_latch[0]) begin
                snap1 <= hist1[SYNC-1]; cnt1 <= 0;
                snap2 <= hist2[SYNC-1]; cnt2 <= 0;
            end else begin
                if (!naddr4016r && cnt1 < 8) cnt1 <= cnt1 + 1;
                if (!naddr4017r && cnt2 < 8) cnt2 <= cnt2 + 1;
            end
            if (addr4016w && !rw) m_latch <= data_in[2:0];
            hist1[0] <= buttons_p1;
            hist2[0] <= buttons_p2;
            for (int i = 1; i < int'(SYNC); i++) begin
                hist1[i] <= hist1[i-1];
                hist2[i] <= hist2[i-1];
            end
        end
    end

    function automatic logic pad_bit(input logic stb, input logic [7:0] live,
                                     input logic [7:0] snap, input int cnt);
        logic [2:0] idx;
        idx = cnt[2:0];
        if (stb) return live[0];
        if (cnt < 8) return snap[idx];
        return FILL;
    endfunction

    always @(negedge clock) begin
        logic b;
        logic oe;
        b = 1'b0;
        if (!naddr4016r) b = pad_bit(m_latch[0], hist1[SYNC-1], snap1, cnt1);
        else if (!naddr4017r) b = pad_bit(m_latch[0], hist2[SYNC-1], snap2, cnt2);
        oe = rw & (!naddr4016r | !naddr4017r);
        check("model data_out", data_out, {OB[7:1], b});
        check("model data_oe", 8'(data_oe), 8'(oe));
        check("model out_latch", 8'(out_latch), 8'(m_latch));
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] v);
        addr4016w = 1'b1; rw = 1'b0; data_in = v;
        step();
        addr4016w = 1'b0; rw = 1'b1; data_in = 8'h00;
    endtask

    task automatic rd(input bit port, input logic [7:0] exp, input string name);
        rw = 1'b1;
        if (port) naddr4017r = 1'b0; else naddr4016r = 1'b0;
        @(negedge clock);
        check(name, data_out, exp);
        step();
        naddr4016r = 1'b1; naddr4017r = 1'b1;
    endtask

    logic [7:0] basic_exp [10];

    initial begin
        basic_exp = '{8'h41, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41, 8'h41};

        // Reset held three cycles with a $4016 read pending.
        naddr4016r = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("reset data_out", data_out, 8'h40);
            check("reset data_oe", 8'(data_oe), 8'h01);
            check("reset out_latch", 8'(out_latch), 8'h00);
            step();
        end
        naddr4016r = 1'b1;
        nreset = 1'b1;
        step();

        // Basic 8-button read and saturation.
        buttons_p1 = 8'b1000_0101;
        repeat (3) step();
        wr(8'h01);
        wr(8'h00);
        for (int i = 0; i < 10; i++) rd(1'b0, basic_exp[i], "basic read");

        // Strobe held: live A, delayed by the synchroniser.
        wr(8'h01);
        for (int j = 0; j < 6; j++) begin
            buttons_p1 = 8'(j & 1);
            if (j >= int'(SYNC)) naddr4016r = 1'b0;
            @(negedge clock);
            if (j >= int'(SYNC)) check("strobe live A", data_out, {OB[7:1], 1'((j - int'(SYNC)) & 1)});
            step();
            naddr4016r = 1'b1;
        end

        // Independent ports.
        buttons_p1 = 8'hFF;
        buttons_p2 = 8'h00;
        repeat (3) step();
        wr(8'h00);
        for (int i = 0; i < 8; i++) begin
            rd(1'b0, 8'h41, "p1 read");
            rd(1'b1, 8'h40, "p2 read");
        end
        rd(1'b1, 8'h41, "p2 fill");

        // RMW-style double read shifts twice.
        buttons_p1 = 8'b0000_0010;
        wr(8'h01);
        repeat (3) step();
        wr(8'h00);
        naddr4016r = 1'b0;
        @(negedge clock);
        check("double read A", data_out, 8'h40);
        step();
        @(negedge clock);
        check("double read B", data_out, 8'h41);
        step();
        naddr4016r = 1'b1;
        step();
        rd(1'b0, 8'h40, "after double Select");

        // Both strobes low: sr1 drives the bus (Start = 0).
        naddr4016r = 1'b0; naddr4017r = 1'b0;
        @(negedge clock);
        check("both strobes", data_out, 8'h40);
        step();
        naddr4016r = 1'b1; naddr4017r = 1'b1;

        // Write with rw=1 is ignored; a real write updates all three bits.
        addr4016w = 1'b1; rw = 1'b1; data_in = 8'h07;
        step();
        addr4016w = 1'b0; data_in = 8'h00;
        @(negedge clock);
        check("ignored write", 8'(out_latch), 8'h00);
        wr(8'h06);
        @(negedge clock);
        check("latch bits", 8'(out_latch), 8'h06);
        step();

        // Write and read in the same cycle (strobe rising, read still shifts).
        addr4016w = 1'b1; rw = 1'b0; data_in = 8'h01; naddr4016r = 1'b0;
        step();
        addr4016w = 1'b0; rw = 1'b1; data_in = 8'h00; naddr4016r = 1'b1;

        // Async reset mid-sequence.
        buttons_p1 = 8'b1000_0101;
        repeat (3) step();
        wr(8'h00);
        rd(1'b0, 8'h41, "pre-reset read");
        rd(1'b0, 8'h40, "pre-reset read");
        rd(1'b0, 8'h41, "pre-reset read");
        #2;
        nreset = 1'b0;
        naddr4016r = 1'b0;
        #1;
        check("async reset latch", 8'(out_latch), 8'h00);
        check("async reset data", data_out, 8'h40);
        nreset = 1'b1;
        naddr4016r = 1'b1;
        step();
        rd(1'b0, 8'h40, "post-reset read");
        rd(1'b0, 8'h40, "post-reset read");

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
